if_bus_arbiter: RTL and testbench
=================================

Name: if_bus_arbiter

Overview:
- Round-robin arbiter and transfer sequencer that shares one physical IF bus (async_en/async_rdy handshake plus data) between N_REQ requesters.
- Sits on the master side of the bus and owns the async_en drive: it selects a requester, presents that requester's data, waits for async_rdy, then returns completion or timeout status.
- All outputs are registered.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- DW, 32, transfer data width
- TIMEOUT, 16, XFER cycles allowed without async_rdy before abort; 0 disables the timeout
- IW, $clog2(N_REQ), owner index width (derived)

Ports:
- clk  in  1  bus clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- req  in  N_REQ  per-requester request; held until done/err
- req_data  in  N_REQ*DW  per-requester data; slice i = req_data[i*DW +: DW]
- gnt  out  N_REQ  one-hot grant, high for the whole XFER phase
- done  out  N_REQ  one-cycle pulse: transfer accepted by async_rdy
- err  out  N_REQ  one-cycle pulse: transfer aborted by timeout
- async_en  out  1  bus enable toward slave
- async_rdy  in  1  slave ready
- bus_data  out  DW  data of current owner
- bus_owner  out  IW  index of current/last owner
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. gnt, done, err, async_en, bus_data, bus_owner, busy and rr_ptr all go to 0. The timeout counter is cleared. Reset mid-XFER drops async_en immediately; no done or err is produced.
- FSM states: IDLE, XFER, GAP.
- IDLE:
  - If req != 0 at a clock edge, winner w = first set bit of req searching from rr_ptr upward, with wrap.
  - Next cycle: state=XFER, async_en=1, gnt[w]=1, bus_data=req_data[w] (latched), bus_owner=w, rr_ptr=(w+1) mod N_REQ, timeout counter=0.
  - If req == 0, stay in IDLE with outputs low.
- XFER:
  - Exit on the first edge with async_rdy=1: next cycle state=GAP, async_en=0, gnt=0, done[w]=1.
  - Otherwise the counter increments. When counter == TIMEOUT-1 and async_rdy=0 (TIMEOUT != 0): next cycle state=GAP, async_en=0, gnt=0, err[w]=1.
  - async_rdy=1 in the timeout cycle: async_rdy wins, so done is raised, not err.
  - bus_data stays constant throughout XFER. Changes on req or req_data are ignored; deasserting req[w] does not abort the transfer.
- GAP: exactly one turnaround cycle with async_en=0. done/err pulses clear, then state goes to IDLE.
- Timing:
  - Best-case latency is 1 cycle from req sampled to async_en=1.
  - Minimum transfer period is 3 cycles (XFER, GAP, IDLE).
  - A requester samples done/err and drops req so that req is low in the IDLE cycle that follows GAP. If req is still high, that is a new request.
- Fairness: after a grant to w, requester w has lowest priority. Every continuously requesting requester is granted within N_REQ transfers.
- async_rdy is ignored in IDLE and GAP.
- Counter width: $clog2(TIMEOUT+1), saturating; it never wraps.

Decomposition:
- Package if_arb_pkg holds:
  - state enum {IDLE, XFER, GAP}
  - localparam helpers for IW and counter width
  - function rr_pick(req, ptr) returning {valid, index}
- Sub-module rr_pick_mask: combinational rotate/priority-encode/unrotate with parameter N_REQ, instantiated once.
- The FSM, counter and output registers live in the top.

Test Plan:
- Single requester: req=4'b0010, data 0xA5A5_0001, async_rdy=1 in the first XFER cycle → async_en high 1 cycle, bus_data=0xA5A5_0001, gnt=4'b0010, done[1] pulse the next cycle, busy low 2 cycles later.
- Contention: req=4'b1111 held, async_rdy tied 1, ptr=0 → grant order 0,1,2,3,0, one grant every 3 cycles.
- Timeout: TIMEOUT=16, async_rdy=0 → async_en high exactly 16 cycles, err[w] pulse, no done, next requester serviced.
- Race: async_rdy rises in the 16th XFER cycle → done pulse, err stays 0.
- Reset mid-XFER: drive rst=0 on XFER cycle 3 → async_en, gnt and busy go 0 asynchronously with no done/err. After release, req=4'b0100 is granted first (ptr=0 search gives 2).
- Stability: req[w] dropped and req_data changed during XFER → bus_data unchanged, transfer completes with done[w].

Source files
------------

// File: rtl/if_arb_pkg.sv
// ---------------------------------------------------------------------------
// if_arb_pkg
// Shared types and helpers for the IF bus arbiter:
//   state_t  - arbiter sequencer states (IDLE, XFER, GAP)
//   iw_of    - owner index width for a given requester count
//   cw_of    - timeout counter width for a given TIMEOUT value
//   rr_pick  - round-robin pick of the first set request at or above ptr
// ---------------------------------------------------------------------------
package if_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int MAX_REQ = 16;

    function automatic int iw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // TIMEOUT == 0 still needs a 1-bit counter so the register is legal.
    function automatic int cw_of(input int timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

    // Returns {valid, index}: first set bit of req searching upward from ptr,
    // wrapping at n.
    function automatic logic [4:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                           input logic [3:0]         ptr,
                                           input int                 n);
        logic [4:0] res;
        int         idx;
        res = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = (int'(ptr) + k) % n;
                if (req[idx[3:0]]) res = {1'b1, 4'(idx)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick_mask.sv
// ---------------------------------------------------------------------------
// rr_pick_mask
// Combinational round-robin selector: rotates the request vector so that
// i_ptr lands on bit 0, priority-encodes the lowest set bit, then rotates the
// result back into requester index space.
// Ports:
//   i_req    - request vector
//   i_ptr    - current highest-priority requester
//   o_valid  - at least one request present
//   o_idx    - winning requester index
// ---------------------------------------------------------------------------
module rr_pick_mask
    import if_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = iw_of(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic             o_valid,
    output logic [IW-1:0]    o_idx
);

    localparam logic [IW:0] NR = (IW + 1)'(N_REQ);

    logic [N_REQ-1:0] w_rot;
    logic [IW:0]      w_ofs;
    logic [IW:0]      w_sum;

    // Doubling the vector lets a plain right shift act as a rotate.
    assign w_rot = N_REQ'({i_req, i_req} >> i_ptr);

    always_comb begin
        w_ofs = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) w_ofs = (IW + 1)'(k);
        end
    end

    // ptr + offset is below 2*N_REQ, so one conditional subtract is the modulo.
    assign w_sum   = {1'b0, i_ptr} + w_ofs;
    assign o_idx   = (w_sum >= NR) ? IW'(w_sum - NR) : IW'(w_sum);
    assign o_valid = |i_req;

endmodule

// File: rtl/if_bus_arbiter.sv
// ---------------------------------------------------------------------------
// if_bus_arbiter
// Round-robin arbiter and transfer sequencer that owns async_en on a shared
// IF bus. A winner is latched in IDLE, its data is driven during XFER until
// async_rdy (done) or timeout (err), then one GAP cycle turns the bus around.
// All outputs are registered.
// Ports:
//   clk        - bus clock
//   rst        - asynchronous reset, active-low
//   req        - per-requester request, held until done/err
//   req_data   - per-requester data, slice i = req_data[i*DW +: DW]
//   gnt        - one-hot grant, high for the whole XFER phase
//   done       - one-cycle pulse, transfer accepted by async_rdy
//   err        - one-cycle pulse, transfer aborted by timeout
//   async_en   - bus enable toward slave
//   async_rdy  - slave ready
//   bus_data   - data of current owner
//   bus_owner  - index of current/last owner
//   busy       - high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module if_bus_arbiter
    import if_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16,
    parameter int IW      = iw_of(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    done,
    output logic [N_REQ-1:0]    err,
    output logic                async_en,
    input  logic                async_rdy,
    output logic [DW-1:0]       bus_data,
    output logic [IW-1:0]       bus_owner,
    output logic                busy
);

    localparam int            CW     = cw_of(TIMEOUT);
    localparam logic [CW-1:0] C_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CW-1:0] C_MAX  = '1;

    state_t           r_state,  w_nxt_state;
    logic [IW-1:0]    r_ptr,    w_nxt_ptr;
    logic [CW-1:0]    r_cnt,    w_nxt_cnt;
    logic [N_REQ-1:0] r_gnt,    w_nxt_gnt;
    logic [N_REQ-1:0] r_done,   w_nxt_done;
    logic [N_REQ-1:0] r_err,    w_nxt_err;
    logic             r_en,     w_nxt_en;
    logic [DW-1:0]    r_data,   w_nxt_data;
    logic [IW-1:0]    r_owner,  w_nxt_owner;
    logic             r_busy,   w_nxt_busy;

    logic             w_pick_vld;
    logic [IW-1:0]    w_pick_idx;
    logic [DW-1:0]    w_slice [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
        assign w_slice[gi] = req_data[gi*DW +: DW];
    end

    rr_pick_mask #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_vld),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_ptr   = r_ptr;
        w_nxt_cnt   = r_cnt;
        w_nxt_gnt   = r_gnt;
        w_nxt_done  = '0;
        w_nxt_err   = '0;
        w_nxt_en    = r_en;
        w_nxt_data  = r_data;
        w_nxt_owner = r_owner;
        case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    w_nxt_state = XFER;
                    w_nxt_en    = 1'b1;
                    w_nxt_gnt   = N_REQ'(1) << w_pick_idx;
                    w_nxt_data  = w_slice[w_pick_idx];
                    w_nxt_owner = w_pick_idx;
                    w_nxt_ptr   = (w_pick_idx == IW'(N_REQ - 1)) ? '0 : w_pick_idx + 1'b1;
                    w_nxt_cnt   = '0;
                end
            end
            XFER: begin
                // async_rdy takes precedence over a timeout in the same cycle.
                if (async_rdy) begin
                    w_nxt_state = GAP;
                    w_nxt_en    = 1'b0;
                    w_nxt_gnt   = '0;
                    w_nxt_done  = r_gnt;
                end else if ((TIMEOUT != 0) && (r_cnt == C_LAST)) begin
                    w_nxt_state = GAP;
                    w_nxt_en    = 1'b0;
                    w_nxt_gnt   = '0;
                    w_nxt_err   = r_gnt;
                end else begin
                    w_nxt_cnt = (r_cnt == C_MAX) ? r_cnt : r_cnt + 1'b1;
                end
            end
            GAP: begin
                w_nxt_state = IDLE;
            end
            default: begin
                w_nxt_state = IDLE;
                w_nxt_en    = 1'b0;
                w_nxt_gnt   = '0;
            end
        endcase
        w_nxt_busy = (w_nxt_state != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_err   <= '0;
            r_en    <= 1'b0;
            r_data  <= '0;
            r_owner <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_ptr   <= w_nxt_ptr;
            r_cnt   <= w_nxt_cnt;
            r_gnt   <= w_nxt_gnt;
            r_done  <= w_nxt_done;
            r_err   <= w_nxt_err;
            r_en    <= w_nxt_en;
            r_data  <= w_nxt_data;
            r_owner <= w_nxt_owner;
            r_busy  <= w_nxt_busy;
        end
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign err       = r_err;
    assign async_en  = r_en;
    assign bus_data  = r_data;
    assign bus_owner = r_owner;
    assign busy      = r_busy;

endmodule

// File: tb/tb_if_bus_arbiter.sv
module tb_if_bus_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  gnt, done, err;
    logic          async_en, async_rdy, busy;
    logic [DW-1:0] bus_data;
    logic [1:0]    bus_owner;

    int ncmp  = 0;
    int nfail = 0;

    // Reference model: transfer phase, rotating pointer, elapsed XFER cycles.
    int          m_ph, m_ptr, m_xc;
    logic [3:0]  m_gnt, m_done, m_err;
    logic        m_en, m_busy;
    logic [31:0] m_data;
    logic [1:0]  m_owner;

    if_bus_arbiter #(
        .N_REQ   (N),
        .DW      (DW),
        .TIMEOUT (TO),
        .IW      (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .async_en  (async_en),
        .async_rdy (async_rdy),
        .bus_data  (bus_data),
        .bus_owner (bus_owner),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    `define CK(tag, o, e) chk(tag, 64'(o), 64'(e))

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_ptr = 0; m_xc = 0;
        m_gnt = '0; m_done = '0; m_err = '0;
        m_en = 1'b0; m_busy = 1'b0; m_data = '0; m_owner = '0;
    endtask

    task automatic model_edge();
        int w;
        m_done = '0;
        m_err  = '0;
        case (m_ph)
            0: begin
                if (req != 4'd0) begin
                    w = -1;
                    for (int k = 0; k < N; k++) begin
                        if (w < 0 && ((req >> ((m_ptr + k) % N)) & 4'd1) != 4'd0)
                            w = (m_ptr + k) % N;
                    end
                    m_ph    = 1;
                    m_en    = 1'b1;
                    m_gnt   = 4'(1 << w);
                    m_data  = 32'(req_data >> (w * DW));
                    m_owner = 2'(w);
                    m_ptr   = (w + 1) % N;
                    m_xc    = 1;
                end
            end
            1: begin
                if (async_rdy) begin
                    m_ph = 2; m_en = 1'b0; m_done = m_gnt; m_gnt = '0;
                end else if (TO != 0 && m_xc == TO) begin
                    m_ph = 2; m_en = 1'b0; m_err = m_gnt; m_gnt = '0;
                end else begin
                    m_xc++;
                end
            end
            default: m_ph = 0;
        endcase
        m_busy = (m_ph != 0);
    endtask

    task automatic check_all();
        `CK("gnt", gnt, m_gnt);
        `CK("done", done, m_done);
        `CK("err", err, m_err);
        `CK("async_en", async_en, m_en);
        `CK("bus_data", bus_data, m_data);
        `CK("bus_owner", bus_owner, m_owner);
        `CK("busy", busy, m_busy);
    endtask

    task automatic step(input logic [3:0] r, input logic rdy);
        req       = r;
        async_rdy = rdy;
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_data(input int idx, input logic [31:0] val);
        req_data[idx*DW +: DW] = val;
    endtask

    initial begin
        int          own_q[$];
        int          at_q[$];
        int          exp_ord[5] = '{0, 1, 2, 3, 0};
        int          en_cnt;
        logic [3:0]  err_seen, done_seen;

        rst = 1'b0; req = '0; async_rdy = 1'b0; req_data = '0;
        model_reset();
        #12;
        `CK("rst_gnt", gnt, 0);
        `CK("rst_done", done, 0);
        `CK("rst_err", err, 0);
        `CK("rst_en", async_en, 0);
        `CK("rst_data", bus_data, 0);
        `CK("rst_owner", bus_owner, 0);
        `CK("rst_busy", busy, 0);
        #10 rst = 1'b1;

        // Single requester, ready in the first XFER cycle.
        set_data(1, 32'hA5A5_0001);
        step(4'b0010, 1'b0);
        `CK("single_en", async_en, 1);
        `CK("single_gnt", gnt, 4'b0010);
        `CK("single_data", bus_data, 32'hA5A5_0001);
        step(4'b0010, 1'b1);
        `CK("single_done", done, 4'b0010);
        `CK("single_en_off", async_en, 0);
        step(4'b0000, 1'b0);
        `CK("single_idle", busy, 0);

        // Move the pointer back to 0 via a transfer for requester 3.
        step(4'b1000, 1'b0);
        step(4'b1000, 1'b1);
        step(4'b0000, 1'b0);

        // Contention with all requesters and ready tied high.
        for (int i = 1; i <= 15; i++) begin
            step(4'b1111, 1'b1);
            if (gnt != 4'd0) begin
                own_q.push_back(int'(bus_owner));
                at_q.push_back(i);
            end
        end
        `CK("cont_count", own_q.size(), 5);
        for (int j = 0; j < own_q.size() && j < 5; j++) begin
            `CK("cont_owner", own_q[j], exp_ord[j]);
            `CK("cont_cycle", at_q[j], 1 + 3 * j);
        end
        step(4'b0000, 1'b0);

        // Timeout: requester 1 never sees ready, then requester 2 is served.
        en_cnt = 0; err_seen = '0; done_seen = '0;
        for (int i = 1; i <= 17; i++) begin
            step(4'b0110, 1'b0);
            if (async_en) en_cnt++;
            err_seen  |= err;
            done_seen |= done;
        end
        `CK("to_en_cycles", en_cnt, 16);
        `CK("to_err", err_seen, 4'b0010);
        `CK("to_done", done_seen, 0);
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        `CK("to_next_owner", bus_owner, 2);
        `CK("to_next_gnt", gnt, 4'b0100);
        step(4'b0100, 1'b1);
        step(4'b0000, 1'b0);

        // Race: ready arrives in the 16th XFER cycle.
        for (int i = 1; i <= 16; i++) step(4'b1000, 1'b0);
        `CK("race_en_still", async_en, 1);
        step(4'b1000, 1'b1);
        `CK("race_done", done, 4'b1000);
        `CK("race_err", err, 0);
        step(4'b0000, 1'b0);

        // Reset during XFER cycle 3.
        step(4'b0001, 1'b0);
        step(4'b0001, 1'b0);
        step(4'b0001, 1'b0);
        #2 rst = 1'b0;
        req = '0;
        #1;
        model_reset();
        `CK("mrst_en", async_en, 0);
        `CK("mrst_gnt", gnt, 0);
        `CK("mrst_busy", busy, 0);
        `CK("mrst_done", done, 0);
        `CK("mrst_err", err, 0);
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;
        step(4'b0100, 1'b0);
        `CK("mrst_first_owner", bus_owner, 2);
        `CK("mrst_first_gnt", gnt, 4'b0100);
        step(4'b0100, 1'b1);
        step(4'b0000, 1'b0);

        // Stability: req dropped and data changed mid-transfer.
        set_data(1, 32'h1234_5678);
        step(4'b0010, 1'b0);
        set_data(1, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            step(4'b0000, 1'b0);
            `CK("stab_data", bus_data, 32'h1234_5678);
        end
        step(4'b0000, 1'b1);
        `CK("stab_done", done, 4'b0010);
        step(4'b0000, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            req_data = {$urandom, $urandom, $urandom, $urandom};
            step(4'($urandom), ($urandom_range(0, 9) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", ncmp, nfail);
        $finish;
    end

endmodule
